regfile_sb: RTL and testbench

Parametrised architectural register file with two combinational read ports, one synchronous write port, write-to-read bypass and a per-register pending scoreboard. It is the next-generation operand-preparation block of the processor and sits between decode and execute. Decode reads operands and busy flags, issue marks destinations pending, and writeback writes results and clears pending. Register 0 is optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_sb.sv | 106 ++++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the architectural register file.
//   REGFILE_DATA_W   : default register width in bits
//   REGFILE_NUM_REGS : default register count (power of two)
//   REGFILE_ADDR_W   : address width derived from the default register count
//   reg_addr_t       : register address at the default size
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_NUM_REGS = 32;
  localparam int REGFILE_ADDR_W   = $clog2(REGFILE_NUM_REGS);

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending vector. Issue marks a destination pending; writeback
// clears it. When both hit the same register in one cycle, the issue wins.
// Busy lookups for both read ports are combinational.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   issue_en, issue_addr   : destination being issued (sets pending)
//   wr_en, wr_addr         : writeback strobe and address (clears pending)
//   rd_addr1, rd_addr2     : read port addresses
//   rd_busy1, rd_busy2     : register at the read address awaits writeback
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  localparam bit P_ZERO   = (ZERO_REG != 0);
  localparam bit P_BYPASS = (BYPASS != 0);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pendingNext;
  logic                w_wrOk;
  logic                w_issueOk;

  // Register 0 never becomes pending when it is hardwired to zero.
  assign w_wrOk    = wr_en    && !(P_ZERO && (wr_addr    == '0));
  assign w_issueOk = issue_en && !(P_ZERO && (issue_addr == '0));

  // Clear first, then set, so a same-cycle issue overrides the writeback.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_wrOk) begin
      w_pendingNext[wr_addr] = 1'b0;
    end
    if (w_issueOk) begin
      w_pendingNext[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  // A writeback landing this cycle makes the forwarded value usable now.
  assign rd_busy1 = r_pending[rd_addr1] &&
                    !(P_BYPASS && w_wrOk && (wr_addr == rd_addr1));
  assign rd_busy2 = r_pending[rd_addr2] &&
                    !(P_BYPASS && w_wrOk && (wr_addr == rd_addr2));

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Architectural register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass, optional hardwired
// zero register and a per-register pending scoreboard.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   rd_addr1/2             : read port addresses
//   rd_data1/2             : read port data
//   rd_busy1/2             : register at the read address awaits writeback
//   wr_en, wr_addr, wr_data: writeback port
//   issue_en, issue_addr   : destination being issued (marks pending)
// ---------------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = REGFILE_DATA_W,
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr
);

  localparam bit P_ZERO   = (ZERO_REG != 0);
  localparam bit P_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wrOk;
  logic [DATA_W-1:0] w_rdData1;
  logic [DATA_W-1:0] w_rdData2;

  assign w_wrOk = wr_en && !(P_ZERO && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrOk) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Override order matters: bypass beats the array, the zero register beats
  // bypass, and reset forces zero even while a write strobe is still high.
  always_comb begin
    w_rdData1 = r_mem[rd_addr1];
    if (P_BYPASS && w_wrOk && (wr_addr == rd_addr1)) begin
      w_rdData1 = wr_data;
    end
    if (P_ZERO && (rd_addr1 == '0)) begin
      w_rdData1 = '0;
    end
    if (!rst_n) begin
      w_rdData1 = '0;
    end
  end

  always_comb begin
    w_rdData2 = r_mem[rd_addr2];
    if (P_BYPASS && w_wrOk && (wr_addr == rd_addr2)) begin
      w_rdData2 = wr_data;
    end
    if (P_ZERO && (rd_addr2 == '0)) begin
      w_rdData2 = '0;
    end
    if (!rst_n) begin
      w_rdData2 = '0;
    end
  end

  assign rd_data1 = w_rdData1;
  assign rd_data2 = w_rdData2;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_busy1   (rd_busy1),
    .rd_busy2   (rd_busy2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Drives four regfile_sb configurations from one shared stimulus stream:
//   inst 0: 32b x 32, zero reg, bypass
//   inst 1: 32b x 32, no zero reg, no bypass
//   inst 2: 16b x 8,  zero reg, bypass
//   inst 3: 16b x 8,  no zero reg, no bypass
// Every output is compared with a per-instance reference model.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rdAddr1, rdAddr2, wrAddr, issueAddr;
  logic [31:0] wrData;
  logic        wrEn, issueEn;

  logic [31:0] a1Data1, a1Data2, a0Data1, a0Data2;
  logic [15:0] b1Data1, b1Data2, b0Data1, b0Data2;
  logic        a1Busy1, a1Busy2, a0Busy1, a0Busy2;
  logic        b1Busy1, b1Busy2, b0Busy1, b0Busy2;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state and per-instance configuration
  logic [31:0] mem  [4][32];
  bit          pend [4][32];
  logic [31:0] dataMask [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};
  int          addrMask [4] = '{31, 31, 7, 7};
  bit          zeroReg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit          bypass   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  string       instName [4] = '{"a11", "a00", "b11", "b00"};

  always #5 clk = ~clk;

  // Full-size configuration with zero register and bypass
  regfile_sb #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) u_a11 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
    .rd_data1(a1Data1), .rd_data2(a1Data2),
    .rd_busy1(a1Busy1), .rd_busy2(a1Busy2),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .issue_en(issueEn), .issue_addr(issueAddr)
  );

  // Full-size configuration, plain register 0 and no bypass
  regfile_sb #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(0), .BYPASS(0)) u_a00 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
    .rd_data1(a0Data1), .rd_data2(a0Data2),
    .rd_busy1(a0Busy1), .rd_busy2(a0Busy2),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .issue_en(issueEn), .issue_addr(issueAddr)
  );

  // Small configuration with zero register and bypass
  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1), .BYPASS(1)) u_b11 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rdAddr1[2:0]), .rd_addr2(rdAddr2[2:0]),
    .rd_data1(b1Data1), .rd_data2(b1Data2),
    .rd_busy1(b1Busy1), .rd_busy2(b1Busy2),
    .wr_en(wrEn), .wr_addr(wrAddr[2:0]), .wr_data(wrData[15:0]),
    .issue_en(issueEn), .issue_addr(issueAddr[2:0])
  );

  // Small configuration, plain register 0 and no bypass
  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(0), .BYPASS(0)) u_b00 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rdAddr1[2:0]), .rd_addr2(rdAddr2[2:0]),
    .rd_data1(b0Data1), .rd_data2(b0Data2),
    .rd_busy1(b0Busy1), .rd_busy2(b0Busy2),
    .wr_en(wrEn), .wr_addr(wrAddr[2:0]), .wr_data(wrData[15:0]),
    .issue_en(issueEn), .issue_addr(issueAddr[2:0])
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic void clearModel();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 32; r++) begin
        mem[k][r]  = '0;
        pend[k][r] = 1'b0;
      end
    end
  endfunction

  // A register accepts writes and issues unless it is the hardwired zero
  function automatic bit writable(input int k, input int a);
    return !(zeroReg[k] && a == 0);
  endfunction

  function automatic logic [31:0] expData(input int k, input logic [4:0] addr);
    int a = int'(addr) & addrMask[k];
    int wa = int'(wrAddr) & addrMask[k];
    if (!rst_n) return '0;
    if (zeroReg[k] && a == 0) return '0;
    if (bypass[k] && wrEn && wa == a) return wrData & dataMask[k];
    return mem[k][a];
  endfunction

  function automatic logic expBusy(input int k, input logic [4:0] addr);
    int a = int'(addr) & addrMask[k];
    int wa = int'(wrAddr) & addrMask[k];
    if (!rst_n) return 1'b0;
    if (bypass[k] && wrEn && wa == a && writable(k, a)) return 1'b0;
    return pend[k][a];
  endfunction

  // Clock-edge behaviour: writeback clears pending, then issue sets it
  function automatic void updateModel();
    for (int k = 0; k < 4; k++) begin
      int wa = int'(wrAddr) & addrMask[k];
      int ia = int'(issueAddr) & addrMask[k];
      if (wrEn && writable(k, wa)) begin
        mem[k][wa]  = wrData & dataMask[k];
        pend[k][wa] = 1'b0;
      end
      if (issueEn && writable(k, ia)) begin
        pend[k][ia] = 1'b1;
      end
    end
  endfunction

  task automatic checkInstance(input int k, input logic [31:0] d1, input logic [31:0] d2,
                               input logic b1, input logic b2);
    checkOutput($sformatf("%s.rd_data1[%0d]", instName[k], rdAddr1), d1, expData(k, rdAddr1));
    checkOutput($sformatf("%s.rd_data2[%0d]", instName[k], rdAddr2), d2, expData(k, rdAddr2));
    checkOutput($sformatf("%s.rd_busy1[%0d]", instName[k], rdAddr1), {31'd0, b1}, {31'd0, expBusy(k, rdAddr1)});
    checkOutput($sformatf("%s.rd_busy2[%0d]", instName[k], rdAddr2), {31'd0, b2}, {31'd0, expBusy(k, rdAddr2)});
  endtask

  task automatic checkAll();
    checkInstance(0, a1Data1, a1Data2, a1Busy1, a1Busy2);
    checkInstance(1, a0Data1, a0Data2, a0Busy1, a0Busy2);
    checkInstance(2, {16'd0, b1Data1}, {16'd0, b1Data2}, b1Busy1, b1Busy2);
    checkInstance(3, {16'd0, b0Data1}, {16'd0, b0Data2}, b0Busy1, b0Busy2);
  endtask

  // One cycle: drive at the falling edge, check mid-cycle, advance the model
  // at the rising edge, and leave outputs settled just after it.
  task automatic applyStimulus(input logic rstVal, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst_n = rstVal; wrEn = we; wrAddr = wa; wrData = wd;
    issueEn = ie; issueAddr = ia; rdAddr1 = r1; rdAddr2 = r2;
    if (!rstVal) clearModel();
    #1;
    checkAll();
    @(posedge clk);
    if (rst_n) updateModel();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    issueEn = 1'b0; issueAddr = '0; rdAddr1 = '0; rdAddr2 = '0;
    clearModel();

    // Reset held with a write strobe active: every read port sees zero
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 32'hDEAD_BEEF, 1'b1, 5'(i), 5'(i), 5'(i + 16));
    end

    // Write r5, then assert reset while a second write to r5 is in flight
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h0000_0011, 1'b0, 5'd0, 5'd5, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd5, 5'd5);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("r5AfterReset", a1Data1, 32'h0);
    checkOutput("r5BusyAfterReset", {31'd0, a1Busy1}, 32'h0);

    // Every address reads zero and idle after reset
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 16));
    end

    // Write 0xAA to r7 while port 1 watches it
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h0000_00AA, 1'b0, 5'd0, 5'd7, 5'd7);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("r7NoBypassNextCycle", a0Data1, 32'h0000_00AA);

    // Write all-ones to r0 and issue r0
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r0ZeroRegData", a1Data1, 32'h0);
    checkOutput("r0ZeroRegBusy", {31'd0, a1Busy1}, 32'h0);
    checkOutput("r0PlainData", a0Data1, 32'hFFFF_FFFF);
    checkOutput("r0PlainBusy", {31'd0, a0Busy1}, 32'h1);

    // Issue r3, then write it back
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3);
    checkOutput("r3BusyAfterIssue", {31'd0, a1Busy2}, 32'h1);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd3);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
    checkOutput("r3DataAfterWb", a1Data2, 32'h0000_1234);
    checkOutput("r3BusyAfterWb", {31'd0, a1Busy2}, 32'h0);

    // Issue and writeback of r9 in the same cycle: issue wins
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0055, 1'b1, 5'd9, 5'd9, 5'd9);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput("r9DataSameCycle", a1Data1, 32'h0000_0055);
    checkOutput("r9BusySameCycle", {31'd0, a1Busy2}, 32'h1);

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 10000; n++) begin
      logic [4:0] wa, ia, r1, r2;
      logic       rv;
      wa = 5'($urandom_range(0, 31));
      ia = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
      rv = ($urandom_range(0, 499) != 0);
      applyStimulus(rv, 1'($urandom_range(0, 1)), wa, $urandom,
                    ($urandom_range(0, 9) < 4), ia, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
